dark_mem_responder: RTL and testbench

//   Memory-side responder for the darkreferee arbitration protocol: accepts one

---
 rtl/dark_mem_responder.sv | 154 +++++++++++++++
 tb/tb_dark_mem_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dark_mem_responder.sv
// Memory-side responder for the darkreferee protocol: one request at a time, fixed latency, one-cycle MEM_VALID.
// Optional MEM_MMIO_LED_EN maps addr[31]==1 accesses to a 4-bit LED register instead of the array.
module dark_mem_responder #(
  parameter int ADDR_W  = 4,
  parameter int LATENCY = 15
) (
  input  logic        XCLK,
  input  logic        XRES,
  input  logic        REF_VALID,
  input  logic        REF_RD,
  input  logic        REF_WR,
  input  logic [31:0] REF_ADDR,
  input  logic [31:0] REF_DATA,
  input  logic [3:0]  REF_BE,
  output logic        MEM_READY,
  output logic        MEM_VALID,
  output logic [31:0] MEM_DATA,
  output logic [3:0]  LED
);

  localparam int         DEPTH = 2 ** ADDR_W;
  localparam logic [7:0] LAST  = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    RELEASE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [7:0]          cnt;
  logic                accept;
  logic                fire;

  logic                rd_q;
  logic                wr_q;
  logic                mmio_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         data_q;
  logic [3:0]          be_q;

  // Zero only at power-up; reset deliberately leaves the contents alone.
  logic [31:0]         mem [DEPTH] = '{default: 32'h0};

  logic                unused_addr_bits;
  assign unused_addr_bits = ^{REF_ADDR[30:ADDR_W+2], REF_ADDR[1:0]};

  assign accept = (state == IDLE) && REF_VALID && (REF_RD || REF_WR);
  assign fire   = (state == BUSY) && (cnt == LAST);

  always_ff @(posedge XCLK) begin
    if (XRES) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    MEM_READY = 1'b0;
    MEM_VALID = 1'b0;
    unique case (state)
      IDLE: begin
        MEM_READY = 1'b1;
        if (accept) state_nxt = BUSY;
      end
      BUSY: begin
        if (fire) state_nxt = RESP;
      end
      RESP: begin
        MEM_VALID = 1'b1;
        state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!REF_VALID) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge XCLK) begin
    if (XRES) begin
      cnt <= 8'd0;
    end else if (accept) begin
      cnt <= 8'd0;
    end else if (state == BUSY) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Request fields are captured once so later REF_* changes cannot alter the access.
  always_ff @(posedge XCLK) begin
    if (XRES) begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      mmio_q <= 1'b0;
      idx_q  <= '0;
      data_q <= 32'h0;
      be_q   <= 4'h0;
    end else if (accept) begin
      rd_q   <= REF_RD;
      wr_q   <= REF_WR;
      mmio_q <= REF_ADDR[31];
      idx_q  <= REF_ADDR[ADDR_W+1:2];
      data_q <= REF_DATA;
      be_q   <= REF_BE;
    end
  end

  always_ff @(posedge XCLK) begin
    if (!XRES && fire && wr_q && !mmio_q) begin
      for (int n = 0; n < 4; n++) begin
        if (be_q[n]) mem[idx_q][8*n +: 8] <= data_q[8*n +: 8];
      end
    end
  end

`ifdef MEM_MMIO_LED_EN
  logic [3:0] led_reg;

  always_ff @(posedge XCLK) begin
    if (XRES) begin
      led_reg <= 4'h0;
    end else if (fire && wr_q && mmio_q && be_q[0]) begin
      led_reg <= data_q[3:0];
    end
  end

  // Non-blocking read returns the pre-write word when rd and wr are both set.
  always_ff @(posedge XCLK) begin
    if (XRES) begin
      MEM_DATA <= 32'h0;
    end else if (fire && rd_q) begin
      MEM_DATA <= mmio_q ? {28'h0, led_reg} : mem[idx_q];
    end
  end

  assign LED = led_reg;
`else
  always_ff @(posedge XCLK) begin
    if (XRES) begin
      MEM_DATA <= 32'h0;
    end else if (fire && rd_q) begin
      MEM_DATA <= mem[idx_q];
    end
  end

  assign LED = mem[0][3:0];
`endif

endmodule

// File: tb/tb_dark_mem_responder.sv
// Scoreboard bench for dark_mem_responder (ADDR_W=4, LATENCY=4); honours MEM_MMIO_LED_EN when defined.
module tb_dark_mem_responder;

  localparam int ADDR_W  = 4;
  localparam int LATENCY = 4;

  logic        XCLK = 1'b0;
  logic        XRES = 1'b1;
  logic        REF_VALID = 1'b0;
  logic        REF_RD = 1'b0;
  logic        REF_WR = 1'b0;
  logic [31:0] REF_ADDR = 32'h0;
  logic [31:0] REF_DATA = 32'h0;
  logic [3:0]  REF_BE = 4'h0;
  logic        MEM_READY;
  logic        MEM_VALID;
  logic [31:0] MEM_DATA;
  logic [3:0]  LED;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_model [16];
  logic [31:0] last_rd = 32'h0;
  logic [3:0]  led_model = 4'h0;
  logic        prev_valid = 1'b0;

  dark_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .XCLK(XCLK), .XRES(XRES), .REF_VALID(REF_VALID), .REF_RD(REF_RD), .REF_WR(REF_WR),
    .REF_ADDR(REF_ADDR), .REF_DATA(REF_DATA), .REF_BE(REF_BE),
    .MEM_READY(MEM_READY), .MEM_VALID(MEM_VALID), .MEM_DATA(MEM_DATA), .LED(LED)
  );

  always #5 XCLK = ~XCLK;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every MEM_VALID pulse consumes one scoreboard entry.
  always @(negedge XCLK) begin
    if (MEM_VALID) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check_output("mem_data", MEM_DATA, exp_q.pop_front());
      end
      if (prev_valid) check_output("valid_pulse_width", 32'd2, 32'd1);
    end
    prev_valid = MEM_VALID;
  end

  function automatic logic [3:0] exp_led();
`ifdef MEM_MMIO_LED_EN
    return led_model;
`else
    return mem_model[0][3:0];
`endif
  endfunction

  function automatic void model_access(input logic rd, input logic wr, input logic [31:0] addr,
                                       input logic [31:0] data, input logic [3:0] be);
    logic [3:0] idx;
    idx = addr[5:2];
    if (rd) begin
`ifdef MEM_MMIO_LED_EN
      last_rd = addr[31] ? {28'h0, led_model} : mem_model[idx];
`else
      last_rd = mem_model[idx];
`endif
    end
    if (wr && !addr[31]) begin
      for (int n = 0; n < 4; n++) if (be[n]) mem_model[idx][8*n +: 8] = data[8*n +: 8];
    end
`ifdef MEM_MMIO_LED_EN
    if (wr && addr[31] && be[0]) led_model = data[3:0];
`endif
  endfunction

  task automatic wait_ready();
    int k = 0;
    @(negedge XCLK);
    while (!MEM_READY && k < 100) begin
      @(negedge XCLK);
      k++;
    end
    if (!MEM_READY) check_output("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be);
    wait_ready();
    REF_VALID = 1'b1;
    REF_RD    = rd;
    REF_WR    = wr;
    REF_ADDR  = addr;
    REF_DATA  = data;
    REF_BE    = be;
    @(posedge XCLK);
  endtask

  task automatic finish_req(input int hold);
    int  n = 0;
    logic ready_seen = 1'b0;
    do begin
      @(negedge XCLK);
      n++;
      if (n == 1) check_output("ready_low_busy", {31'h0, MEM_READY}, 32'd0);
      REF_ADDR = 32'hFFFF_FFFC;
      REF_DATA = 32'h0BAD_0BAD;
    end while (!MEM_VALID && n < 40);
    check_output("latency", n, LATENCY + 1);
    repeat (hold) begin
      @(negedge XCLK);
      if (MEM_READY) ready_seen = 1'b1;
    end
    REF_VALID = 1'b0;
    if (hold > 0) begin
      check_output("ready_held_low", {31'h0, ready_seen}, 32'd0);
      @(negedge XCLK);
      check_output("ready_after_drop", {31'h0, MEM_READY}, 32'd1);
    end
    check_output("led", {28'h0, LED}, {28'h0, exp_led()});
  endtask

  task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] be, input int hold);
    model_access(rd, wr, addr, data, be);
    exp_q.push_back(last_rd);
    start_req(rd, wr, addr, data, be);
    finish_req(hold);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 16; i++) mem_model[i] = 32'h0;
    $display("[TB] start");
    repeat (2) @(posedge XCLK);
    @(negedge XCLK);
    check_output("reset_ready", {31'h0, MEM_READY}, 32'd1);
    check_output("reset_valid", {31'h0, MEM_VALID}, 32'd0);
    check_output("reset_data", MEM_DATA, 32'h0);
    check_output("reset_led", {28'h0, LED}, 32'h0);
    XRES = 1'b0;

    // REF_VALID without RD or WR must be ignored.
    REF_VALID = 1'b1;
    repeat (3) begin
      @(negedge XCLK);
      check_output("ignore_no_rdwr", {31'h0, MEM_READY}, 32'd1);
    end
    REF_VALID = 1'b0;

    apply_stimulus(1'b0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0);
    apply_stimulus(1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'h0, 0);
    apply_stimulus(1'b0, 1'b1, 32'h0000_0004, 32'h1122_3344, 4'b0101, 0);
    apply_stimulus(1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'h0, 10);

    apply_stimulus(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0005, 4'h1, 0);
    apply_stimulus(1'b0, 1'b1, 32'h8000_0000, 32'h0000_000A, 4'hF, 0);
    apply_stimulus(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0);
    apply_stimulus(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 0);

    // Reset while BUSY with cnt==2 aborts the write to mem[2].
    start_req(1'b0, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 4'hF);
    repeat (3) @(negedge XCLK);
    XRES = 1'b1;
    REF_VALID = 1'b0;
    @(negedge XCLK);
    XRES = 1'b0;
    last_rd = 32'h0;
    led_model = 4'h0;
    check_output("abort_ready", {31'h0, MEM_READY}, 32'd1);
    check_output("abort_valid", {31'h0, MEM_VALID}, 32'd0);
    check_output("abort_data", MEM_DATA, 32'h0);
    check_output("abort_led", {28'h0, LED}, {28'h0, exp_led()});
    apply_stimulus(1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 0);

    apply_stimulus(1'b1, 1'b1, 32'h0000_0004, 32'h0000_0000, 4'hF, 0);
    apply_stimulus(1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'h0, 0);
    apply_stimulus(1'b0, 1'b1, 32'h0000_0044, 32'h1234_5678, 4'hF, 0);
    apply_stimulus(1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'h0, 0);
    apply_stimulus(1'b0, 1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'h0, 0);
    apply_stimulus(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 0);

    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge XCLK);
      k++;
    end
    check_output("scoreboard_drained", exp_q.size(), 32'd0);
    repeat (3) @(negedge XCLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
